// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core among NUM_REQ requesters.
// Latency: accept in T, core_start in T+1, response one cycle after core_done or watchdog expiry.
// Backpressure: one operation in flight; req_ready stays low until the response handshake completes.
module aes_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int KEY_W   = 128,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*KEY_W-1:0]     req_key,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic                         core_start,
  output logic [KEY_W-1:0]             core_key,
  output logic [DATA_W-1:0]            core_data,
  input  logic                         core_done,
  input  logic [DATA_W-1:0]            core_result,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   resp_id,
  output logic [DATA_W-1:0]            resp_data,
  output logic                         resp_err,
  output logic                         busy,
  output logic [15:0]                  ops_cnt
);

  localparam int          IDW     = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      grant_id_q;
  logic [15:0]         timer_q;
  logic                core_start_q;
  logic [KEY_W-1:0]    core_key_q;
  logic [DATA_W-1:0]   core_data_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic                resp_err_q;
  logic                busy_q;
  logic [15:0]         ops_cnt_q;

  logic                grant_vld;
  logic [IDW-1:0]      grant_idx;
  logic [IDW-1:0]      cand_idx;
  int                  cand;

  logic [KEY_W-1:0]    key_arr  [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  // Unflatten the per-requester operand buses
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign key_arr[i]  = req_key[i*KEY_W +: KEY_W];
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last served requester
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!grant_vld && req_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Grant is only offered while idle, so a single operation is ever in flight
  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Control FSM with registered outputs; core_done outside BUSY is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= IDW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      timer_q      <= '0;
      core_start_q <= 1'b0;
      core_key_q   <= '0;
      core_data_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      ops_cnt_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            core_key_q   <= key_arr[grant_idx];
            core_data_q  <= data_arr[grant_idx];
            grant_id_q   <= grant_idx;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= '0;
          state_q <= ST_BUSY;
        end
        ST_BUSY: begin
          timer_q <= timer_q + 16'd1;
          // A done arriving on the watchdog's last cycle still counts as success
          if (core_done) begin
            resp_data_q  <= core_result;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else if (timer_q == TO_LAST) begin
            resp_data_q  <= '0;
            resp_err_q   <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Served requester drops to lowest priority, even after a timeout
          if (resp_ready) begin
            rr_ptr_q     <= grant_id_q;
            ops_cnt_q    <= ops_cnt_q + 16'd1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_key   = core_key_q;
  assign core_data  = core_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = grant_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign ops_cnt    = ops_cnt_q;

endmodule
